// File: rtl/nf10_encap_ipfix_pkg.sv
// nf10_encap_ipfix_pkg: shared states, header constants and byte helper for the IPv4 fixup block
package nf10_encap_ipfix_pkg;
  typedef enum logic [1:0] {HEAD, HOLD, STREAM} state_t;
  localparam int ETH_HDR_LEN = 14;
  localparam int ENCAP_HDR_LEN = 34;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0] IP_VER_IHL = 8'h45;
  localparam int OFS_ETHERTYPE = 12;
  localparam int OFS_TOTLEN = 16;
  localparam int OFS_CSUM = 24;
  function automatic logic [7:0] get_byte(input logic [255:0] d, input int k);
    return d[8*k+:8];
  endfunction
endpackage

// File: rtl/nf10_encap_ipfix_ip_hdr_csum.sv
// ip_hdr_csum: folded, inverted one's-complement sum of ten 16-bit IPv4 header words
module ip_hdr_csum (
  input  logic [9:0][15:0] i_words,
  output logic [15:0]      o_csum
);
  logic [19:0] w_sum;
  logic [16:0] w_f1;
  logic [15:0] w_f2;
  // 20-bit accumulation; two folds always absorb every carry
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 10; i++) w_sum = w_sum + 20'(i_words[i]);
    w_f1 = 17'(w_sum[15:0]) + 17'(w_sum[19:16]);
    w_f2 = w_f1[15:0] + 16'(w_f1[16]);
    o_csum = ~w_f2;
  end
endmodule

// File: rtl/nf10_encap_ipfix.sv
// nf10_encap_ipfix: fills IPv4 total length and checksum of encap frames; ENCAP_IPFIX_STATS_EN adds counters
module nf10_encap_ipfix
  import nf10_encap_ipfix_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH = 256,
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int TOTAL_LENGTH_POS = 0
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,
`ifdef ENCAP_IPFIX_STATS_EN
  output logic [31:0]                       fixed_count,
  output logic [31:0]                       bypass_count,
`endif
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready
);
  state_t r_state, w_next;
  logic [C_S_AXIS_DATA_WIDTH-1:0] r_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] r_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] r_user;
  logic r_last, r_cand, w_cand;
  logic [15:0] w_len, w_tl, w_csum;
  logic [9:0][15:0] w_words;
  logic [C_M_AXIS_DATA_WIDTH-1:0] w_patched;
  assign w_len = s_axis_tuser[TOTAL_LENGTH_POS+:16];
  assign w_tl = r_user[TOTAL_LENGTH_POS+:16] - 16'(ETH_HDR_LEN);
  assign w_cand = &s_axis_tstrb && !s_axis_tlast
    && {get_byte(s_axis_tdata, OFS_ETHERTYPE), get_byte(s_axis_tdata, OFS_ETHERTYPE+1)} == ETHERTYPE_IPV4
    && get_byte(s_axis_tdata, ETH_HDR_LEN) == IP_VER_IHL
    && s_axis_tdata[8*OFS_TOTLEN+:16] == 16'h0 && s_axis_tdata[8*OFS_CSUM+:16] == 16'h0
    && w_len >= 16'(ENCAP_HDR_LEN);
  // header words from the held beat0, with the last word read live from the unconsumed beat1
  always_comb begin
    for (int i = 0; i < 9; i++)
      w_words[i] = {get_byte(r_data, ETH_HDR_LEN+2*i), get_byte(r_data, ETH_HDR_LEN+2*i+1)};
    w_words[1] = w_tl;
    w_words[5] = 16'h0;
    w_words[9] = {s_axis_tdata[7:0], s_axis_tdata[15:8]};
    w_patched = r_data;
    w_patched[8*OFS_TOTLEN+:16] = {w_tl[7:0], w_tl[15:8]};
    w_patched[8*OFS_CSUM+:16] = {w_csum[7:0], w_csum[15:8]};
  end
  ip_hdr_csum u_csum (.i_words(w_words), .o_csum(w_csum));
  // next state and stream muxing; reset forces both handshakes off
  always_comb begin
    w_next = r_state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata = r_data;
    m_axis_tstrb = r_strb;
    m_axis_tuser = r_user;
    m_axis_tlast = r_last;
    case (r_state)
      HEAD: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) w_next = HOLD;
      end
      HOLD: begin
        m_axis_tvalid = r_cand ? s_axis_tvalid : 1'b1;
        m_axis_tdata = r_cand ? w_patched : r_data;
        if (m_axis_tvalid && m_axis_tready) w_next = r_last ? HEAD : STREAM;
      end
      default: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata = s_axis_tdata;
        m_axis_tstrb = s_axis_tstrb;
        m_axis_tuser = s_axis_tuser;
        m_axis_tlast = s_axis_tlast;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) w_next = HEAD;
      end
    endcase
    if (axi_reset) begin
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
    end
  end
  // state register and beat0 hold register
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      r_state <= HEAD;
      r_data <= '0;
      r_strb <= '0;
      r_user <= '0;
      r_last <= 1'b0;
      r_cand <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == HEAD && s_axis_tvalid) begin
        r_data <= s_axis_tdata;
        r_strb <= s_axis_tstrb;
        r_user <= s_axis_tuser;
        r_last <= s_axis_tlast;
        r_cand <= w_cand;
      end
    end
  end
`ifdef ENCAP_IPFIX_STATS_EN
  logic w_beat0_fire;
  assign w_beat0_fire = r_state == HOLD && m_axis_tvalid && m_axis_tready;
  // per-frame statistics on the beat0 master handshake
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      fixed_count <= '0;
      bypass_count <= '0;
    end else if (w_beat0_fire) begin
      if (r_cand) fixed_count <= fixed_count + 32'd1;
      else bypass_count <= bypass_count + 32'd1;
    end
  end
`else
`endif
endmodule

// File: tb/tb_nf10_encap_ipfix.sv
// tb_nf10_encap_ipfix: scoreboard bench for the IPv4 fixup block (counters checked with ENCAP_IPFIX_STATS_EN)
module tb_nf10_encap_ipfix;
  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } beat_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [255:0] s_tdata = '0, m_tdata;
  logic [31:0] s_tstrb = '0, m_tstrb;
  logic [127:0] s_tuser = '0, m_tuser;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tready, m_tvalid, m_tlast, m_ready = 1'b1;
`ifdef ENCAP_IPFIX_STATS_EN
  logic [31:0] fixed_count, bypass_count;
`endif
  int checks = 0, failures = 0, cyc = 0;
  beat_t q[$];
  beat_t frm[$];
  int tl_cyc[$];
  beat_t mon_e;
  localparam logic [159:0] HDR_A = 160'h4500_0000_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;
  nf10_encap_ipfix dut (
    .axi_aclk(clk), .axi_reset(rst),
`ifdef ENCAP_IPFIX_STATS_EN
    .fixed_count(fixed_count), .bypass_count(bypass_count),
`endif
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // scoreboard: every master handshake must match the oldest expected beat
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat got d=%h last=%b", m_tdata, m_tlast);
      end else begin
        mon_e = q.pop_front();
        if ({m_tdata, m_tstrb, m_tuser, m_tlast} !== mon_e) begin
          failures++;
          $display("FAIL beat got d=%h s=%h l=%b exp d=%h s=%h l=%b", m_tdata, m_tstrb, m_tlast, mon_e.d, mon_e.s, mon_e.l);
        end
      end
      if (m_tlast) tl_cyc.push_back(cyc);
    end
  end
  // reference beat0 fixup
  function automatic beat_t patch(input beat_t b0, input beat_t b1);
    beat_t r = b0;
    logic [15:0] len = b0.u[15:0], tl, w, cs;
    logic [31:0] sum = 0;
    if (b0.s == '1 && !b0.l && b0.d[103:96] == 8'h08 && b0.d[111:104] == 8'h00 && b0.d[119:112] == 8'h45
        && b0.d[143:128] == 16'h0 && b0.d[207:192] == 16'h0 && len >= 16'd34) begin
      tl = len - 16'd14;
      for (int i = 0; i < 10; i++) begin
        if (i == 9) w = {b1.d[7:0], b1.d[15:8]};
        else w = {b0.d[8*(14+2*i)+:8], b0.d[8*(15+2*i)+:8]};
        if (i == 1) w = tl;
        if (i == 5) w = 16'h0;
        sum = sum + 32'(w);
      end
      while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
      cs = ~sum[15:0];
      r.d[135:128] = tl[15:8];
      r.d[143:136] = tl[7:0];
      r.d[199:192] = cs[15:8];
      r.d[207:200] = cs[7:0];
    end
    return r;
  endfunction
  task automatic mk(input logic [159:0] hdr, input logic [15:0] etype, input int len);
    logic [7:0] by [256];
    int nb = (len + 31) / 32;
    beat_t b;
    for (int k = 0; k < 256; k++) by[k] = 8'($urandom());
    by[12] = etype[15:8];
    by[13] = etype[7:0];
    for (int i = 0; i < 20; i++) by[14+i] = hdr[159-8*i -: 8];
    frm.delete();
    for (int n = 0; n < nb; n++) begin
      b.d = '0;
      b.s = '0;
      for (int j = 0; j < 32; j++)
        if (n*32 + j < len) begin
          b.d[8*j+:8] = by[n*32+j];
          b.s[j] = 1'b1;
        end
      b.u = {$urandom(), $urandom(), $urandom(), $urandom()};
      b.u[15:0] = 16'(len);
      b.l = (n == nb - 1);
      frm.push_back(b);
    end
  endtask
  task automatic push_exp(input int nb);
    for (int n = 0; n < nb; n++)
      q.push_back(n == 0 ? patch(frm[0], frm.size() > 1 ? frm[1] : frm[0]) : frm[n]);
  endtask
  task automatic drive(input int nb, input int gap1);
    int w;
    for (int n = 0; n < nb; n++) begin
      s_tdata = frm[n].d;
      s_tstrb = frm[n].s;
      s_tuser = frm[n].u;
      s_tlast = frm[n].l;
      if (n == 1 && gap1 > 0) begin
        s_tvalid = 1'b0;
        repeat (gap1) @(posedge clk);
        #1;
      end
      s_tvalid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!s_tready && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (!s_tready) begin
        failures++;
        $display("FAIL s_ready_timeout beat=%0d got=%b exp=1", n, s_tready);
        s_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
  endtask
  task automatic send(input int gap1);
    push_exp(frm.size());
    drive(frm.size(), gap1);
  endtask
  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got s_ready=%b m_valid=%b exp 0/0", s_tready, m_tvalid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_tvalid, m_tlast, m_tdata, m_tstrb, m_tuser} !== '0) begin
      failures++;
      $display("FAIL reset_out got v=%b l=%b d=%h exp zeros", m_tvalid, m_tlast, m_tdata);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", s_tready);
    end
`ifdef ENCAP_IPFIX_STATS_EN
    checks++;
    if (fixed_count !== 0 || bypass_count !== 0) begin
      failures++;
      $display("FAIL reset_counts got %0d/%0d exp 0/0", fixed_count, bypass_count);
    end
`endif
    @(posedge clk);
    #1;
  endtask
  task automatic test_bypass;
    mk(160'h4500_0040_1234_0000_4006_b1e6_0a00_0001_0a00_0002, 16'h0800, 78);
    send(0);
    drain();
`ifdef ENCAP_IPFIX_STATS_EN
    checks++;
    if (bypass_count !== 32'd1 || fixed_count !== 32'd0) begin
      failures++;
      $display("FAIL bypass_counts got %0d/%0d exp 1/0", bypass_count, fixed_count);
    end
`endif
  endtask
  task automatic test_fixup;
    logic [255:0] got, rest;
    int n = 0;
    mk(HDR_A, 16'h0800, 129);
    fork
      send(0);
      begin
        @(negedge clk);
        while (!(m_tvalid && m_ready) && n < 100) begin
          @(negedge clk);
          n++;
        end
        got = m_tdata;
      end
    join
    drain();
    checks++;
    if ({got[135:128], got[143:136]} !== 16'h0073) begin
      failures++;
      $display("FAIL fixup_totlen got=%h exp=0073", {got[135:128], got[143:136]});
    end
    checks++;
    if ({got[199:192], got[207:200]} !== 16'hB861) begin
      failures++;
      $display("FAIL fixup_csum got=%h exp=b861", {got[199:192], got[207:200]});
    end
    rest = frm[0].d;
    rest[143:128] = got[143:128];
    rest[207:192] = got[207:192];
    checks++;
    if (got !== rest) begin
      failures++;
      $display("FAIL fixup_other got=%h exp=%h", got, rest);
    end
  endtask
  task automatic test_boundaries;
    logic [159:0] h46 = HDR_A;
    logic [159:0] hck = HDR_A;
    h46[159:152] = 8'h46;
    hck[79:72] = 8'h12;
    mk(HDR_A, 16'h0800, 34);   send(0);
    mk(HDR_A, 16'h0800, 33);   send(0);
    mk(h46, 16'h0800, 100);    send(0);
    mk(hck, 16'h0800, 100);    send(0);
    mk(HDR_A, 16'h86dd, 100);  send(0);
    mk(160'h4500_0000_abcd_0000_4006_0000_ffff_ffff_ffff_fffe, 16'h0800, 250); send(0);
    drain();
  endtask
  task automatic test_single_beat;
    mk(HDR_A, 16'h0800, 32);
    frm[0].u[15:0] = 16'd60;
    send(0);
    drain();
    m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL single_head got s_ready=%b exp=1", s_tready);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
  endtask
  task automatic test_hold_stall;
    beat_t e0;
    int n = 0;
    mk(HDR_A, 16'h0800, 129);
    e0 = patch(frm[0], frm[1]);
    m_ready = 1'b0;
    fork
      send(3);
      begin
        @(negedge clk);
        while (!(s_tvalid && s_tready) && n < 100) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if (m_tdata !== e0.d || m_tvalid !== (k >= 3)) begin
            failures++;
            $display("FAIL hold_stable k=%0d got v=%b d=%h exp v=%b d=%h", k, m_tvalid, m_tdata, k >= 3, e0.d);
          end
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain();
  endtask
  task automatic test_back_to_back;
    logic [159:0] h = HDR_A;
    tl_cyc.delete();
    for (int f = 0; f < 3; f++) begin
      h[127:112] = 16'($urandom());
      mk(h, 16'h0800, 80);
      send(0);
    end
    drain();
    checks++;
    if (tl_cyc.size() != 3) begin
      failures++;
      $display("FAIL b2b_frames got=%0d exp=3", tl_cyc.size());
    end else
      for (int f = 1; f < 3; f++) begin
        checks++;
        if (tl_cyc[f] - tl_cyc[f-1] != 4) begin
          failures++;
          $display("FAIL b2b_period frame=%0d got=%0d exp=4", f, tl_cyc[f] - tl_cyc[f-1]);
        end
      end
  endtask
  task automatic test_reset_mid;
    mk(HDR_A, 16'h0800, 129);
    push_exp(2);
    drive(2, 0);
    drain();
    m_ready = 1'b0;
    s_tdata = frm[2].d;
    s_tstrb = frm[2].s;
    s_tuser = frm[2].u;
    s_tlast = frm[2].l;
    s_tvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_valid got=%b exp=0", m_tvalid);
    end
`ifdef ENCAP_IPFIX_STATS_EN
    checks++;
    if (fixed_count !== 0 || bypass_count !== 0) begin
      failures++;
      $display("FAIL midrst_counts got %0d/%0d exp 0/0", fixed_count, bypass_count);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_head got s_ready=%b m_valid=%b exp 1/0", s_tready, m_tvalid);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    mk(160'h4500_0000_0001_0000_4011_0000_0a01_0203_0a04_0506, 16'h0800, 200);
    send(0);
    drain();
  endtask
  initial begin
    test_reset();
    test_bypass();
    test_fixup();
    test_boundaries();
    test_single_beat();
    test_hold_stall();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
